// File: rtl/peripheral_uart_rx_pkg.sv
// peripheral_uart_rx_pkg: register map, STATUS/CTRL bit positions and receiver FSM states
package peripheral_uart_rx_pkg;

   localparam logic [3:0] ADDR_RX_DATA = 4'h0;
   localparam logic [3:0] ADDR_STATUS  = 4'h2;
   localparam logic [3:0] ADDR_CTRL    = 4'h4;

   localparam int ST_AVAIL = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_FERR  = 2;
   localparam int ST_OVR   = 3;

   localparam int CTRL_FLUSH = 0;
   localparam int CTRL_CLR   = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_e;

   function automatic logic [15:0] status_word(logic ovr, logic ferr, logic full, logic avail);
      logic [15:0] s;
      s = '0;
      s[ST_OVR]   = ovr;
      s[ST_FERR]  = ferr;
      s[ST_FULL]  = full;
      s[ST_AVAIL] = avail;
      return s;
   endfunction

endpackage

// File: rtl/peripheral_uart_rx_if.sv
// peripheral_uart_rx_if: J1 I/O bus slice seen by the UART receiver
interface peripheral_uart_rx_if;

   logic [15:0] d_in;
   logic [15:0] d_out;
   logic [3:0]  addr;
   logic        cs;
   logic        rd;
   logic        wr;

   modport master (output d_in, addr, cs, rd, wr, input d_out);
   modport slave  (input d_in, addr, cs, rd, wr, output d_out);

endinterface

// File: rtl/peripheral_uart_rx_core.sv
// uart_rx_core: 2-FF synchroniser, bit timer and 8N1 deserialising FSM
module uart_rx_core
   import peripheral_uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       rx_strobe,
   output logic [7:0] rx_byte,
   output logic       frame_err_pulse
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   rx_state_e     state_q, state_d;
   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          strobe_q, strobe_d;
   logic          ferr_q, ferr_d;

   // Frame sequencing: centre on the start bit, then sample one bit period apart
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      strobe_d = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!sync2_q) state_d = START;
         end
         START: if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = sync2_q ? IDLE : DATA;
         end
         DATA: if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            shift_d = {sync2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
         end
         STOP: if (cnt_q == FULL_LAST) begin
            cnt_d    = '0;
            strobe_d = sync2_q;
            ferr_d   = !sync2_q;
            state_d  = sync2_q ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            cnt_d = '0;
            if (sync2_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Synchroniser presets to the idle-high line level so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         strobe_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         sync1_q  <= uart_rx;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         strobe_q <= strobe_d;
         ferr_q   <= ferr_d;
      end
   end

   assign rx_strobe       = strobe_q;
   assign rx_byte         = shift_q;
   assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/peripheral_uart_rx.sv
// peripheral_uart_rx: memory-mapped UART receiver with receive FIFO on the J1 I/O bus
module peripheral_uart_rx
   import peripheral_uart_rx_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   peripheral_uart_rx_if.slave  bus,
   input  logic                 uart_rx,
   output logic                 rx_avail
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int AW           = $clog2(FIFO_DEPTH);

   logic        rx_strobe, frame_err_pulse;
   logic [7:0]  rx_byte;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        overrun_q, overrun_d, frame_err_q, frame_err_d, rd_prev_q;
   logic [15:0] d_out_q, d_out_d, rdata;
   logic        empty, full, rd_sel, wr_ctrl, flush, clr, pop, push;
   logic        unused_d_in;

   assign unused_d_in = ^bus.d_in[15:2];

   uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
      .clk             (clk),
      .rst             (rst),
      .uart_rx         (uart_rx),
      .rx_strobe       (rx_strobe),
      .rx_byte         (rx_byte),
      .frame_err_pulse (frame_err_pulse)
   );

   // Bus decode and FIFO control: flush beats push/pop, a same-cycle pop frees room for a push
   always_comb begin
      empty       = wr_ptr_q == rd_ptr_q;
      full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      rx_avail    = ~empty;
      rd_sel      = bus.cs & bus.rd;
      wr_ctrl     = bus.cs & bus.wr & (bus.addr == ADDR_CTRL);
      flush       = wr_ctrl & bus.d_in[CTRL_FLUSH];
      clr         = wr_ctrl & bus.d_in[CTRL_CLR];
      pop         = rd_sel & ~rd_prev_q & (bus.addr == ADDR_RX_DATA) & ~empty & ~flush;
      push        = rx_strobe & ~flush & (~full | pop);
      wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d    = flush ? wr_ptr_q : rd_ptr_q + {{AW{1'b0}}, pop};
      overrun_d   = (rx_strobe & ~flush & full & ~pop) | (overrun_q & ~clr);
      frame_err_d = frame_err_pulse | (frame_err_q & ~clr);
      rdata       = bus.addr == ADDR_STATUS ? status_word(overrun_q, frame_err_q, full, ~empty) :
                    (bus.addr == ADDR_RX_DATA && !empty) ? {8'h00, mem_q[rd_ptr_q[AW-1:0]]} : 16'h0000;
      d_out_d     = (!rd_sel || (bus.addr == ADDR_RX_DATA && rd_prev_q)) ? d_out_q : rdata;
   end

   // Control and read-data registers; RX_DATA is captured only on the rd rising edge so a held rd keeps the popped byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rd_prev_q   <= 1'b0;
         d_out_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         rd_prev_q   <= bus.rd;
         d_out_q     <= d_out_d;
      end
   end

   // FIFO storage needs no reset; the pointers define which entries are valid
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
   end

   assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_uart_rx.sv
// tb_peripheral_uart_rx: scoreboard bench for the UART receiver against a queue-based model
`timescale 1ns/1ps
module tb_peripheral_uart_rx;
   import peripheral_uart_rx_pkg::*;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = CLK_FREQ / BAUD;

   typedef struct {
      logic [15:0] val;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_rx = 1'b1;
   logic rx_avail;
   logic rsp_v = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] model_q[$];
   bit   m_ovr = 0;
   bit   m_ferr = 0;
   exp_t exp_q[$];

   peripheral_uart_rx_if bus ();

   peripheral_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .uart_rx  (uart_rx),
      .rx_avail (rx_avail)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [15:0] m_status();
      logic [15:0] s;
      s = '0;
      s[3] = m_ovr;
      s[2] = m_ferr;
      s[1] = model_q.size() == 8;
      s[0] = model_q.size() != 0;
      return s;
   endfunction

   always @(posedge clk) rsp_v <= bus.cs & bus.rd;

   always @(negedge clk) begin
      exp_t e;
      if (rsp_v) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_read: got %h expected no response", bus.d_out);
         end else begin
            e = exp_q.pop_front();
            check(e.name, bus.d_out, e.val);
         end
      end
   end

   task automatic bus_read(input logic [3:0] a, input string name);
      exp_t e;
      e.name = name;
      if (a == 4'h0) e.val = model_q.size() != 0 ? {8'h00, model_q.pop_front()} : 16'h0000;
      else if (a == 4'h2) begin
         e.val = m_status();
         check({name, "_rx_avail"}, {15'b0, rx_avail}, {15'b0, model_q.size() != 0});
      end else e.val = 16'h0000;
      exp_q.push_back(e);
      bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
      @(negedge clk);
      bus.cs = 1'b0; bus.rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      if (a == 4'h4) begin
         if (d[0]) model_q.delete();
         if (d[1]) begin m_ovr = 0; m_ferr = 0; end
      end
      bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
      @(negedge clk);
      bus.cs = 1'b0; bus.wr = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_frame(b, stop);
      repeat (CPB) @(negedge clk);
      if (!stop) m_ferr = 1;
      else if (model_q.size() == 8) m_ovr = 1;
      else model_q.push_back(b);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      logic [3:0] a;
      bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;
      repeat (3) @(negedge clk);
      check("reset_d_out", bus.d_out, 16'h0000);
      check("reset_rx_avail", {15'b0, rx_avail}, 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      send_byte(8'h55, 1'b1);
      bus_read(ADDR_STATUS, "status_55");
      bus_read(ADDR_RX_DATA, "data_55");
      bus_read(ADDR_STATUS, "status_after_pop");

      for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
      bus_read(ADDR_STATUS, "status_overrun");
      for (int i = 0; i < 9; i++) bus_read(ADDR_RX_DATA, "data_fill");
      bus_write(ADDR_CTRL, 16'h0002);
      bus_read(ADDR_STATUS, "status_ovr_cleared");

      send_byte(8'hC3, 1'b0);
      bus_read(ADDR_STATUS, "status_frame_err");
      bus_write(ADDR_CTRL, 16'h0002);
      bus_read(ADDR_STATUS, "status_ferr_cleared");

      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      bus_read(ADDR_STATUS, "status_glitch");

      uart_rx = 1'b0;
      repeat (3 * CPB + CPB / 2) @(negedge clk);
      rst = 1'b1;
      uart_rx = 1'b1;
      model_q.delete(); m_ovr = 0; m_ferr = 0;
      repeat (2) @(negedge clk);
      check("midframe_reset_d_out", bus.d_out, 16'h0000);
      check("midframe_reset_rx_avail", {15'b0, rx_avail}, 16'h0000);
      rst = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      send_byte(8'hA3, 1'b1);
      bus_read(ADDR_STATUS, "status_after_reset");
      bus_read(ADDR_RX_DATA, "data_a3");
      bus_read(ADDR_STATUS, "status_a3_empty");

      for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i), 1'b1);
      bus_read(ADDR_STATUS, "status_full");
      found = 0;
      fork
         send_frame(8'hEE, 1'b1);
         begin
            for (int k = 0; k < 20 * CPB && !found; k++) begin
               @(negedge clk);
               if (dut.u_core.rx_strobe) found = 1;
            end
            if (found) bus_read(ADDR_RX_DATA, "data_pop_with_push");
         end
      join
      repeat (CPB) @(negedge clk);
      check("push_pop_strobe_seen", {15'b0, found}, 16'h0001);
      if (found) model_q.push_back(8'hEE);
      else m_ovr = 1;
      bus_read(ADDR_STATUS, "status_push_pop_full");
      for (int i = 0; i < 8; i++) bus_read(ADDR_RX_DATA, "data_order");
      bus_read(ADDR_STATUS, "status_drained");

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: send_byte(8'($urandom), $urandom_range(0, 7) != 0);
            4, 5:       bus_read(ADDR_RX_DATA, "rand_data");
            6:          bus_read(ADDR_STATUS, "rand_status");
            7:          bus_write(ADDR_CTRL, 16'($urandom));
            8: begin
               a = 4'($urandom_range(0, 15));
               if (a == 4'h0 || a == 4'h2 || a == 4'h4) a = 4'hF;
               bus_read(a, "rand_unmapped_read");
            end
            default: begin
               a = 4'($urandom_range(0, 15));
               if (a == 4'h4) a = 4'h6;
               bus_write(a, 16'($urandom));
            end
         endcase
      end
      bus_read(ADDR_STATUS, "rand_final_status");

      repeat (5) @(negedge clk);
      check("scoreboard_drain", 16'(exp_q.size()), 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
